// File: rtl/adc_sclk_gen.sv
// Programmable serial-clock generator for the ADC shift path: divides clk_in by a loadable
// half-period count, emits rise/fall strobes, and runs free or as a counted burst.
module adc_sclk_gen #(
   parameter int CNT_W   = 14,
   parameter int BURST_W = 6
) (
   input  logic               clk_in,
   input  logic               reset_n,
   input  logic [CNT_W-1:0]   div_half,
   input  logic               div_load,
   input  logic               mode,
   input  logic [BURST_W-1:0] burst_len,
   input  logic               start,
   input  logic               stop,
   output logic               sclk,
   output logic               sclk_rise,
   output logic               sclk_fall,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   div_act, div_act_nxt;
   logic [CNT_W-1:0]   div_pend, div_pend_nxt;
   logic               pend_vld, pend_vld_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [BURST_W:0]   per, per_nxt;
   logic               mode_l, mode_l_nxt;
   logic [BURST_W-1:0] burst_l, burst_l_nxt;
   logic               stop_req, stop_req_nxt;
   logic               sclk_nxt, rise_nxt, fall_nxt, busy_nxt, done_nxt;
   logic               tick, fall_tick, last_fall;

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         div_act   <= '0;
         div_pend  <= '0;
         pend_vld  <= 1'b0;
         cnt       <= '0;
         per       <= '0;
         mode_l    <= 1'b0;
         burst_l   <= '0;
         stop_req  <= 1'b0;
         sclk      <= 1'b0;
         sclk_rise <= 1'b0;
         sclk_fall <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         div_act   <= div_act_nxt;
         div_pend  <= div_pend_nxt;
         pend_vld  <= pend_vld_nxt;
         cnt       <= cnt_nxt;
         per       <= per_nxt;
         mode_l    <= mode_l_nxt;
         burst_l   <= burst_l_nxt;
         stop_req  <= stop_req_nxt;
         sclk      <= sclk_nxt;
         sclk_rise <= rise_nxt;
         sclk_fall <= fall_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

   // Divisor changes made while running only take effect on a falling toggle,
   // so a high phase is never cut short or stretched.
   always_comb begin
      state_nxt    = state;
      div_act_nxt  = div_act;
      div_pend_nxt = div_pend;
      pend_vld_nxt = pend_vld;
      cnt_nxt      = cnt;
      per_nxt      = per;
      mode_l_nxt   = mode_l;
      burst_l_nxt  = burst_l;
      stop_req_nxt = stop_req;
      sclk_nxt     = sclk;
      rise_nxt     = 1'b0;
      fall_nxt     = 1'b0;
      done_nxt     = 1'b0;
      tick         = 1'b0;
      fall_tick    = 1'b0;
      last_fall    = 1'b0;

      case (state)
         IDLE: begin
            cnt_nxt  = '0;
            sclk_nxt = 1'b0;
            if (div_load) begin
               div_act_nxt = div_half;
            end
            if (start) begin
               state_nxt    = RUN;
               mode_l_nxt   = mode;
               burst_l_nxt  = burst_len;
               per_nxt      = '0;
               stop_req_nxt = 1'b0;
            end
         end
         RUN, DRAIN: begin
            if (div_load) begin
               div_pend_nxt = div_half;
               pend_vld_nxt = 1'b1;
            end
            if (stop && state == RUN) begin
               stop_req_nxt = 1'b1;
               state_nxt    = DRAIN;
            end
            tick      = (cnt == div_act);
            fall_tick = tick && sclk;
            if (tick) begin
               cnt_nxt  = '0;
               sclk_nxt = ~sclk;
               rise_nxt = ~sclk;
               fall_nxt = sclk;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
            if (fall_tick) begin
               per_nxt      = per + 1'b1;
               pend_vld_nxt = 1'b0;
               if (div_load) begin
                  div_act_nxt = div_half;
               end else if (pend_vld) begin
                  div_act_nxt = div_pend;
               end
               last_fall = stop_req || (!mode_l && per == {1'b0, burst_l});
               if (last_fall) begin
                  state_nxt    = IDLE;
                  stop_req_nxt = 1'b0;
                  done_nxt     = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_adc_sclk_gen.sv
// Scoreboard bench for adc_sclk_gen: a phase-arithmetic model predicts every strobe edge,
// and a negedge monitor pops and compares them as the DUT produces them.
module tb_adc_sclk_gen;

   localparam int CNT_W   = 14;
   localparam int BURST_W = 6;

   logic               clk_in = 1'b0;
   logic               reset_n;
   logic [CNT_W-1:0]   div_half;
   logic               div_load;
   logic               mode;
   logic [BURST_W-1:0] burst_len;
   logic               start;
   logic               stop;
   logic               sclk, sclk_rise, sclk_fall, busy, done;

   typedef struct {
      int e;
      bit r;
      bit f;
      bit d;
   } ev_t;

   ev_t exp_q[$];
   ev_t ev;
   int  checks    = 0;
   int  failures  = 0;
   int  edge_cnt  = 0;
   int  busy_cnt  = 0;
   int  model_div = 0;

   adc_sclk_gen #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
      .clk_in    (clk_in),
      .reset_n   (reset_n),
      .div_half  (div_half),
      .div_load  (div_load),
      .mode      (mode),
      .burst_len (burst_len),
      .start     (start),
      .stop      (stop),
      .sclk      (sclk),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d (edge %0d)", name, actual, expected, edge_cnt);
      end
   endtask

   // Monitor: every strobe the DUT raises must match the next predicted event.
   always @(negedge clk_in) begin
      if (reset_n) begin
         if (busy) busy_cnt++;
         if (sclk_rise || sclk_fall || done) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_event", int'({sclk_rise, sclk_fall, done}), 0);
            end else begin
               ev = exp_q.pop_front();
               checkOutput("event_edge", edge_cnt, ev.e);
               checkOutput("event_flags", int'({sclk_rise, sclk_fall, done, sclk, busy}),
                           int'({ev.r, ev.f, ev.d, ev.r, !ev.d}));
            end
         end
      end
   end

   // Predicts the run phase by phase: each phase lasts d+1 cycles, loads land on falls.
   task automatic model_run(input int t0, input bit md, input int blen, input int stop_e,
                            input int l1_e, input int l1_v, input int l2_e, input int l2_v,
                            output int done_e);
      int d, cur, falls, rise, fall;
      bit ap1, ap2, term;
      d = model_div; cur = t0; falls = 0; ap1 = 0; ap2 = 0;
      done_e = t0 + 2;
      for (int n = 0; n < 500; n++) begin
         rise = cur + d + 1;
         exp_q.push_back('{rise, 1'b1, 1'b0, 1'b0});
         fall = rise + d + 1;
         if (!ap1 && l1_e > t0 && l1_e <= fall) begin d = l1_v; ap1 = 1; end
         if (!ap2 && l2_e > t0 && l2_e <= fall) begin d = l2_v; ap2 = 1; end
         falls++;
         term = (!md && falls == blen + 1) || (stop_e > t0 && stop_e < fall);
         exp_q.push_back('{fall, 1'b0, 1'b1, term});
         cur = fall;
         if (term) begin
            done_e = fall;
            break;
         end
      end
      if (!ap1 && l1_e > t0) d = l1_v;
      if (!ap2 && l2_e > t0) d = l2_v;
      model_div = d;
   endtask

   task automatic applyStimulus(input string name, input int ld_mode, input int div0, input bit md,
                                input int blen, input int stop_off, input bit stop_with_start,
                                input int l1_off, input int l1_val, input int l2_off, input int l2_val,
                                input bit busy_start);
      int t0, done_e, last_e, c0, k, bs_e, stop_e, l1_e, l2_e;
      @(negedge clk_in);
      if (ld_mode == 1) begin
         div_half = CNT_W'(div0);
         div_load = 1'b1;
         @(negedge clk_in);
         div_load  = 1'b0;
         model_div = div0;
      end
      t0        = edge_cnt + 1;
      div_load  = (ld_mode == 2);
      div_half  = (ld_mode == 2) ? CNT_W'(div0) : CNT_W'($urandom_range(0, 9));
      if (ld_mode == 2) model_div = div0;
      mode      = md;
      burst_len = BURST_W'(blen);
      start     = 1'b1;
      stop      = stop_with_start;
      stop_e    = (stop_off > 0) ? t0 + stop_off : -1;
      l1_e      = (l1_off > 0) ? t0 + l1_off : -1;
      l2_e      = (l2_off > 0) ? t0 + l2_off : -1;
      c0        = busy_cnt;
      model_run(t0, md, blen, stop_e, l1_e, l1_val, l2_e, l2_val, done_e);
      bs_e = busy_start ? t0 + 1 + int'($urandom_range(0, done_e - t0 - 2)) : -1;
      last_e = done_e;
      if (l1_e > last_e) last_e = l1_e;
      if (l2_e > last_e) last_e = l2_e;
      if (stop_e > last_e) last_e = stop_e;
      @(negedge clk_in);
      while (edge_cnt + 1 <= last_e + 2) begin
         k         = edge_cnt + 1;
         start     = busy_start && (k == bs_e);
         stop      = (k == stop_e);
         div_load  = (k == l1_e) || (k == l2_e);
         div_half  = (k == l2_e) ? CNT_W'(l2_val) : (k == l1_e) ? CNT_W'(l1_val)
                                 : CNT_W'($urandom_range(0, 9));
         mode      = 1'($urandom);
         burst_len = BURST_W'($urandom);
         @(negedge clk_in);
      end
      start    = 1'b0;
      stop     = 1'b0;
      div_load = 1'b0;
      checkOutput({name, "_busy_cycles"}, busy_cnt - c0, done_e - t0);
      checkOutput({name, "_missing_events"}, exp_q.size(), 0);
      checkOutput({name, "_idle_sclk"}, int'(sclk), 0);
      checkOutput({name, "_idle_busy"}, int'(busy), 0);
      exp_q.delete();
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog timeout actual=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int t0, done_e, dv, lm, bl, so, l1, l2;
      bit md, bs, sws;
      reset_n   = 1'b0;
      div_half  = '0;
      div_load  = 1'b0;
      mode      = 1'b0;
      burst_len = '0;
      start     = 1'b0;
      stop      = 1'b0;
      repeat (3) @(negedge clk_in);
      checkOutput("reset_sclk", int'(sclk), 0);
      checkOutput("reset_rise", int'(sclk_rise), 0);
      checkOutput("reset_fall", int'(sclk_fall), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      reset_n = 1'b1;

      applyStimulus("burst_div0", 1, 0, 0, 3, -1, 0, -1, 0, -1, 0, 0);
      applyStimulus("cont_stop", 1, 4, 1, 0, 25, 0, -1, 0, -1, 0, 0);
      applyStimulus("reload_high", 1, 2, 1, 0, 40, 0, 4, 5, -1, 0, 0);
      applyStimulus("double_load", 1, 3, 1, 0, 30, 0, 2, 7, 5, 1, 0);

      // Reset in the middle of a burst while sclk is high.
      @(negedge clk_in);
      div_half = CNT_W'(3);
      div_load = 1'b1;
      @(negedge clk_in);
      div_load  = 1'b0;
      model_div = 3;
      mode      = 1'b0;
      burst_len = BURST_W'(5);
      start     = 1'b1;
      t0        = edge_cnt + 1;
      model_run(t0, 1'b0, 5, -1, -1, 0, -1, 0, done_e);
      @(negedge clk_in);
      start = 1'b0;
      for (int i = 0; i < 50 && !sclk; i++) @(negedge clk_in);
      checkOutput("rst_sclk_high_before", int'(sclk), 1);
      #1 reset_n = 1'b0;
      #1;
      checkOutput("rst_sclk", int'(sclk), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_strobes", int'({sclk_rise, sclk_fall}), 0);
      exp_q.delete();
      model_div = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_in);
         checkOutput("rst_no_done", int'(done), 0);
      end
      reset_n = 1'b1;

      applyStimulus("after_reset_div0", 0, 0, 0, 1, -1, 0, -1, 0, -1, 0, 0);
      applyStimulus("start_stop_busy", 2, 1, 0, 4, -1, 1, -1, 0, -1, 0, 1);
      applyStimulus("max_burst", 1, 0, 0, 63, -1, 0, -1, 0, -1, 0, 0);
      applyStimulus("load_with_start", 2, 3, 0, 2, 5, 0, -1, 0, -1, 0, 0);
      applyStimulus("stop_while_low", 1, 3, 0, 6, 2, 0, -1, 0, -1, 0, 0);

      for (int i = 0; i < 20; i++) begin
         dv  = $urandom_range(0, 5);
         lm  = $urandom_range(0, 2);
         md  = 1'($urandom_range(0, 1));
         bl  = $urandom_range(0, 5);
         so  = md ? int'($urandom_range(1, 40))
                  : (($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : -1);
         l1  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : -1;
         l2  = (l1 > 0 && $urandom_range(0, 1) == 1) ? l1 + int'($urandom_range(1, 10)) : -1;
         bs  = 1'($urandom_range(0, 1));
         sws = ($urandom_range(0, 3) == 0);
         applyStimulus($sformatf("rand%0d", i), lm, dv, md, bl, so, sws,
                       l1, int'($urandom_range(0, 5)), l2, int'($urandom_range(0, 5)), bs);
      end

      repeat (2) @(negedge clk_in);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
